// File: rtl/bpred_resolve_queue_if.sv
// Fetch-to-execute branch resolution bus: prediction records from fetch,
// resolutions from execute, and the predictor update / RAS repair / redirect
// results returned by the resolve queue.
interface bpred_resolve_queue_if #(
  parameter int META_W = 12
);
  // Fetch side: predicted control-transfer records
  logic              fetch_push;
  logic [31:0]       fetch_pc4;
  logic              fetch_p_dir;
  logic [31:0]       fetch_p_target;
  logic [META_W-1:0] fetch_meta;
  logic              fetch_is_call;
  logic              fetch_is_ret;
  logic              queue_full;

  // Execute side: branch resolution
  logic              ex_valid;
  logic [31:0]       ex_pc4;
  logic              ex_dir;
  logic [31:0]       ex_target;
  logic              soin_bpredictor_stall;

  // Predictor update bus
  logic              execute_bpredictor_update;
  logic [31:0]       execute_bpredictor_PC4;
  logic [31:0]       execute_bpredictor_target;
  logic              execute_bpredictor_dir;
  logic              execute_bpredictor_miss;
  logic [META_W-1:0] execute_bpredictor_bimodal;

  // RAS repair strobes
  logic              execute_missPred;
  logic              execute_c_r_after_r;
  logic              execute_isCall;

  // Front-end redirect and status
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              order_error;
  logic [31:0]       resolved_count;
  logic [31:0]       miss_count;

  modport master (
    output fetch_push, fetch_pc4, fetch_p_dir, fetch_p_target, fetch_meta,
           fetch_is_call, fetch_is_ret,
    output ex_valid, ex_pc4, ex_dir, ex_target, soin_bpredictor_stall,
    input  queue_full,
    input  execute_bpredictor_update, execute_bpredictor_PC4,
           execute_bpredictor_target, execute_bpredictor_dir,
           execute_bpredictor_miss, execute_bpredictor_bimodal,
    input  execute_missPred, execute_c_r_after_r, execute_isCall,
    input  redirect_valid, redirect_pc, order_error, resolved_count, miss_count
  );

  modport slave (
    input  fetch_push, fetch_pc4, fetch_p_dir, fetch_p_target, fetch_meta,
           fetch_is_call, fetch_is_ret,
    input  ex_valid, ex_pc4, ex_dir, ex_target, soin_bpredictor_stall,
    output queue_full,
    output execute_bpredictor_update, execute_bpredictor_PC4,
           execute_bpredictor_target, execute_bpredictor_dir,
           execute_bpredictor_miss, execute_bpredictor_bimodal,
    output execute_missPred, execute_c_r_after_r, execute_isCall,
    output redirect_valid, redirect_pc, order_error, resolved_count, miss_count
  );
endinterface

// File: rtl/bpred_resolve_queue.sv
// Branch resolve queue: in-order record of every predicted control transfer.
// Execute pops the oldest record on resolution, compares it with the actual
// outcome and drives predictor update, RAS repair and front-end redirect one
// cycle later. A misprediction flushes every younger record.
module bpred_resolve_queue #(
  parameter int DEPTH  = 8,
  parameter int META_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  bpred_resolve_queue_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  function automatic logic mispredict(input logic        act_dir,
                                      input logic [31:0] act_tgt,
                                      input logic        pred_dir,
                                      input logic [31:0] pred_tgt);
    // Wrong direction, or taken to somewhere other than the predicted target
    return (act_dir != pred_dir) | (act_dir & (act_tgt != pred_tgt));
  endfunction

  // Entry storage (data only, never reset)
  logic [31:0]       pc4_mem  [DEPTH];
  logic              dir_mem  [DEPTH];
  logic [31:0]       tgt_mem  [DEPTH];
  logic [META_W-1:0] meta_mem [DEPTH];
  logic              call_mem [DEPTH];
  logic              ret_mem  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             last_was_ret;
  logic             order_err;
  logic [31:0]      res_cnt;
  logic [31:0]      miss_cnt;

  // ---- stage p0: decode of this cycle's push / resolve ----
  logic              h_dir, h_call, h_ret;
  logic [31:0]       h_pc4, h_tgt;
  logic [META_W-1:0] h_meta;
  logic              full_p0, res_p0, pop_p0, miss_p0, flush_p0, push_ok_p0, err_p0;

  assign h_pc4  = pc4_mem[head];
  assign h_dir  = dir_mem[head];
  assign h_tgt  = tgt_mem[head];
  assign h_meta = meta_mem[head];
  assign h_call = call_mem[head];
  assign h_ret  = ret_mem[head];

  assign full_p0    = (count == FULL_CNT);
  assign res_p0     = bus.ex_valid & ~bus.soin_bpredictor_stall;
  assign pop_p0     = res_p0 & (count != '0);
  assign miss_p0    = mispredict(bus.ex_dir, bus.ex_target, h_dir, h_tgt);
  assign flush_p0   = pop_p0 & miss_p0;
  // A full queue still accepts a push when the head leaves the same cycle;
  // anything pushed alongside a flush is wrong-path and discarded.
  assign push_ok_p0 = bus.fetch_push & ~flush_p0 & (~full_p0 | pop_p0);
  assign err_p0     = (bus.fetch_push & full_p0 & ~pop_p0)
                    | (res_p0 & (count == '0))
                    | (pop_p0 & (bus.ex_pc4 != h_pc4));

  // Write an accepted prediction record at the tail
  always_ff @(posedge clk) begin
    if (push_ok_p0) begin
      pc4_mem[tail]  <= bus.fetch_pc4;
      dir_mem[tail]  <= bus.fetch_p_dir;
      tgt_mem[tail]  <= bus.fetch_p_target;
      meta_mem[tail] <= bus.fetch_meta;
      call_mem[tail] <= bus.fetch_is_call;
      ret_mem[tail]  <= bus.fetch_is_ret;
    end
  end

  // Head/tail/count bookkeeping; a flush empties the queue outright
  always_ff @(posedge clk) begin
    if (reset || flush_p0) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok_p0) tail <= tail + PTR_W'(1);
      if (pop_p0)     head <= head + PTR_W'(1);
      count <= count + CNT_W'(push_ok_p0) - CNT_W'(pop_p0);
    end
  end

  // Sticky error, committed-return history and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      order_err    <= 1'b0;
      last_was_ret <= 1'b0;
      res_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      if (err_p0) order_err <= 1'b1;
      if (pop_p0) begin
        last_was_ret <= h_ret;
        res_cnt      <= res_cnt + 32'd1;
      end
      if (flush_p0) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  // ---- stage p1: registered resolution results ----
  logic              vld_p1, redirect_vld_p1, miss_pred_p1, crr_p1, is_call_p1;
  logic              dir_p1, miss_p1;
  logic [31:0]       pc4_p1, tgt_p1, redirect_pc_p1;
  logic [META_W-1:0] meta_p1;

  // Strobes pulse for one cycle after a pop; data holds until the next pop
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1          <= 1'b0;
      redirect_vld_p1 <= 1'b0;
      miss_pred_p1    <= 1'b0;
      crr_p1          <= 1'b0;
      is_call_p1      <= 1'b0;
      dir_p1          <= 1'b0;
      miss_p1         <= 1'b0;
      pc4_p1          <= '0;
      tgt_p1          <= '0;
      redirect_pc_p1  <= '0;
      meta_p1         <= '0;
    end else begin
      vld_p1          <= pop_p0;
      redirect_vld_p1 <= flush_p0;
      miss_pred_p1    <= flush_p0;
      crr_p1          <= pop_p0 & (h_call | h_ret) & last_was_ret;
      is_call_p1      <= pop_p0 & h_call;
      if (pop_p0) begin
        dir_p1         <= bus.ex_dir;
        miss_p1        <= miss_p0;
        pc4_p1         <= bus.ex_pc4;
        tgt_p1         <= bus.ex_target;
        redirect_pc_p1 <= bus.ex_dir ? bus.ex_target : bus.ex_pc4;
        meta_p1        <= h_meta;
      end
    end
  end

  assign bus.queue_full                 = full_p0;
  assign bus.execute_bpredictor_update  = vld_p1;
  assign bus.execute_bpredictor_PC4     = pc4_p1;
  assign bus.execute_bpredictor_target  = tgt_p1;
  assign bus.execute_bpredictor_dir     = dir_p1;
  assign bus.execute_bpredictor_miss    = miss_p1;
  assign bus.execute_bpredictor_bimodal = meta_p1;
  assign bus.execute_missPred           = miss_pred_p1;
  assign bus.execute_c_r_after_r        = crr_p1;
  assign bus.execute_isCall             = is_call_p1;
  assign bus.redirect_valid             = redirect_vld_p1;
  assign bus.redirect_pc                = redirect_pc_p1;
  assign bus.order_error                = order_err;
  assign bus.resolved_count             = res_cnt;
  assign bus.miss_count                 = miss_cnt;

endmodule

// File: tb/tb_bpred_resolve_queue.sv
// Bench for bpred_resolve_queue: a driver issues directed and random
// push/resolve traffic and feeds a queue-based reference model; a monitor
// compares DUT outputs against the expectations the model queued.
module tb_bpred_resolve_queue;
  localparam int DEPTH  = 8;
  localparam int META_W = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bpred_resolve_queue_if #(.META_W(META_W)) bus ();

  bpred_resolve_queue #(.DEPTH(DEPTH), .META_W(META_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0]       pc4;
    logic              dir;
    logic [31:0]       tgt;
    logic [META_W-1:0] meta;
    logic              call;
    logic              ret;
  } entry_t;

  typedef struct {
    int                cyc;
    logic [31:0]       pc4;
    logic [31:0]       tgt;
    logic              dir;
    logic              miss;
    logic [META_W-1:0] meta;
    logic              crr;
    logic              is_call;
    logic [31:0]       rpc;
  } resp_t;

  typedef struct {
    int          cyc;
    logic        full;
    logic        err;
    logic [31:0] rc;
    logic [31:0] mc;
    resp_t       held;
  } snap_t;

  entry_t mq[$];
  resp_t  rq[$];
  snap_t  sq[$];

  logic        m_err, m_last_ret;
  logic [31:0] m_rc, m_mc;
  resp_t       m_held;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  task automatic set_idle();
    bus.fetch_push = 1'b0;
    bus.fetch_pc4 = '0;
    bus.fetch_p_dir = 1'b0;
    bus.fetch_p_target = '0;
    bus.fetch_meta = '0;
    bus.fetch_is_call = 1'b0;
    bus.fetch_is_ret = 1'b0;
    bus.ex_valid = 1'b0;
    bus.ex_pc4 = '0;
    bus.ex_dir = 1'b0;
    bus.ex_target = '0;
    bus.soin_bpredictor_stall = 1'b0;
  endtask

  task automatic set_push(input logic [31:0] pc4, input logic dir, input logic [31:0] tgt,
                          input logic [META_W-1:0] meta, input logic call, input logic ret);
    bus.fetch_push = 1'b1;
    bus.fetch_pc4 = pc4;
    bus.fetch_p_dir = dir;
    bus.fetch_p_target = tgt;
    bus.fetch_meta = meta;
    bus.fetch_is_call = call;
    bus.fetch_is_ret = ret;
  endtask

  task automatic set_res(input logic [31:0] pc4, input logic dir, input logic [31:0] tgt);
    bus.ex_valid = 1'b1;
    bus.ex_pc4 = pc4;
    bus.ex_dir = dir;
    bus.ex_target = tgt;
    bus.soin_bpredictor_stall = 1'b0;
  endtask

  // Reference model: applies one clock's worth of the queue rules to the
  // inputs currently driven and queues what the DUT must show next cycle.
  task automatic model_step();
    entry_t h, e;
    resp_t  r;
    snap_t  s;
    bit res, popped, flush, full, miss;
    popped = 0;
    flush  = 0;
    if (reset) begin
      mq.delete();
      m_err = 1'b0;
      m_last_ret = 1'b0;
      m_rc = '0;
      m_mc = '0;
      m_held = '{default: '0};
    end else begin
      res  = bus.ex_valid && !bus.soin_bpredictor_stall;
      full = (mq.size() == DEPTH);
      if (res) begin
        if (mq.size() == 0) m_err = 1'b1;
        else begin
          h = mq.pop_front();
          popped = 1;
          miss = (bus.ex_dir != h.dir) || (bus.ex_dir && (bus.ex_target != h.tgt));
          if (bus.ex_pc4 != h.pc4) m_err = 1'b1;
          r.cyc = cyc + 1;
          r.pc4 = bus.ex_pc4;
          r.tgt = bus.ex_target;
          r.dir = bus.ex_dir;
          r.miss = miss;
          r.meta = h.meta;
          r.crr = (h.call || h.ret) && m_last_ret;
          r.is_call = h.call;
          r.rpc = bus.ex_dir ? bus.ex_target : bus.ex_pc4;
          rq.push_back(r);
          m_held = r;
          m_last_ret = h.ret;
          m_rc = m_rc + 32'd1;
          if (miss) begin
            flush = 1;
            m_mc = m_mc + 32'd1;
            mq.delete();
          end
        end
      end
      if (bus.fetch_push && !flush) begin
        if (full && !popped) m_err = 1'b1;
        else begin
          e.pc4 = bus.fetch_pc4;
          e.dir = bus.fetch_p_dir;
          e.tgt = bus.fetch_p_target;
          e.meta = bus.fetch_meta;
          e.call = bus.fetch_is_call;
          e.ret = bus.fetch_is_ret;
          mq.push_back(e);
        end
      end
    end
    s.cyc  = cyc + 1;
    s.full = (mq.size() == DEPTH);
    s.err  = m_err;
    s.rc   = m_rc;
    s.mc   = m_mc;
    s.held = m_held;
    sq.push_back(s);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  // Monitor: compares every cycle's status and the queued update responses
  always @(negedge clk) begin : monitor
    snap_t s;
    resp_t r;
    if (sq.size() != 0 && sq[0].cyc == cyc) begin
      s = sq.pop_front();
      chk("queue_full", 32'(bus.queue_full), 32'(s.full));
      chk("order_error", 32'(bus.order_error), 32'(s.err));
      chk("resolved_count", bus.resolved_count, s.rc);
      chk("miss_count", bus.miss_count, s.mc);
      chk("upd_pc4", bus.execute_bpredictor_PC4, s.held.pc4);
      chk("upd_target", bus.execute_bpredictor_target, s.held.tgt);
      chk("upd_dir", 32'(bus.execute_bpredictor_dir), 32'(s.held.dir));
      chk("upd_miss", 32'(bus.execute_bpredictor_miss), 32'(s.held.miss));
      chk("upd_bimodal", 32'(bus.execute_bpredictor_bimodal), 32'(s.held.meta));
      chk("redirect_pc", bus.redirect_pc, s.held.rpc);
      if (rq.size() != 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        chk("update_pulse", 32'(bus.execute_bpredictor_update), 32'd1);
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(r.miss));
        chk("missPred", 32'(bus.execute_missPred), 32'(r.miss));
        chk("c_r_after_r", 32'(bus.execute_c_r_after_r), 32'(r.crr));
        chk("isCall", 32'(bus.execute_isCall), 32'(r.is_call));
      end else begin
        chk("update_idle", 32'(bus.execute_bpredictor_update), 32'd0);
        chk("redirect_idle", 32'(bus.redirect_valid), 32'd0);
        chk("missPred_idle", 32'(bus.execute_missPred), 32'd0);
        chk("c_r_after_r_idle", 32'(bus.execute_c_r_after_r), 32'd0);
        chk("isCall_idle", 32'(bus.execute_isCall), 32'd0);
      end
    end
    if (done) begin
      chk("pending_responses", 32'(rq.size()), 32'd0);
      chk("pending_snapshots", 32'(sq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Driver: directed scenarios followed by random traffic
  initial begin : driver
    entry_t h;
    logic [31:0] pc, tgt;
    logic dir, call, ret;
    set_idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Correctly predicted taken branch
    set_push(32'h104, 1'b1, 32'h200, 12'hABC, 1'b0, 1'b0); cycle();
    set_res(32'h104, 1'b1, 32'h200); cycle();
    cycle();

    // Direction mispredict on the oldest of three; push in the flush cycle is dropped
    for (int i = 0; i < 3; i++) begin
      set_push(32'h104 + 32'(i * 8), 1'b1, 32'h200 + 32'(i * 16), 12'(i + 1), 1'b0, 1'b0);
      cycle();
    end
    set_res(32'h104, 1'b0, 32'h0);
    set_push(32'h500, 1'b1, 32'h600, 12'h777, 1'b0, 1'b0);
    cycle();
    cycle();

    // Taken with the wrong target
    set_push(32'h204, 1'b1, 32'h200, 12'h055, 1'b0, 1'b0); cycle();
    set_res(32'h204, 1'b1, 32'h300); cycle();
    cycle();

    // Fill to full, overflow push, then push+pop while full and wrap-around
    for (int i = 0; i < DEPTH; i++) begin
      set_push(32'h1000 + 32'(i * 4), 1'b0, 32'h0, 12'(i), 1'b0, 1'b0); cycle();
    end
    set_push(32'h2000, 1'b0, 32'h0, 12'hFFF, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 20; i++) begin
      set_push(32'h1000 + 32'((DEPTH + i) * 4), 1'b0, 32'h0, 12'(DEPTH + i), 1'b0, 1'b0);
      set_res(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
      cycle();
    end
    for (int i = 0; i < DEPTH; i++) begin
      set_res(32'h1000 + 32'((20 + i) * 4), 1'b0, 32'h0); cycle();
    end
    cycle();

    // Return then call: second pop repairs with c_r_after_r; plain pops after do not
    set_push(32'h3004, 1'b0, 32'h0, 12'h001, 1'b0, 1'b1); cycle();
    set_push(32'h3008, 1'b0, 32'h0, 12'h002, 1'b1, 1'b0); cycle();
    set_push(32'h300C, 1'b0, 32'h0, 12'h003, 1'b0, 1'b0); cycle();
    set_push(32'h3010, 1'b0, 32'h0, 12'h004, 1'b0, 1'b0); cycle();
    set_res(32'h3004, 1'b0, 32'h0); cycle();
    set_res(32'h3008, 1'b0, 32'h0); cycle();
    set_res(32'h300C, 1'b0, 32'h0); cycle();
    set_res(32'h3010, 1'b0, 32'h0); cycle();
    cycle();

    // Stalled resolution is ignored, then resolves normally
    set_push(32'h4004, 1'b1, 32'h4400, 12'h0AA, 1'b0, 1'b0); cycle();
    set_res(32'h4004, 1'b1, 32'h4400);
    bus.soin_bpredictor_stall = 1'b1;
    cycle();
    set_res(32'h4004, 1'b1, 32'h4400); cycle();
    cycle();

    // Reset while holding entries and with a resolve asserted
    set_push(32'h5004, 1'b0, 32'h0, 12'h011, 1'b0, 1'b0); cycle();
    set_push(32'h5008, 1'b0, 32'h0, 12'h022, 1'b0, 1'b0); cycle();
    reset = 1'b1;
    set_res(32'h5004, 1'b0, 32'h0);
    cycle();
    reset = 1'b0;
    cycle();

    // Resolve against the now-empty queue
    set_res(32'h5004, 1'b0, 32'h0); cycle();
    cycle();
    reset = 1'b1; cycle(); reset = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 127) == 0) reset = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        pc   = 32'h8000 + 32'($urandom_range(0, 255) * 4);
        dir  = 1'($urandom_range(0, 1));
        tgt  = 32'h9000 + 32'($urandom_range(0, 3) * 4);
        call = ($urandom_range(0, 3) == 0);
        ret  = call ? 1'b0 : ($urandom_range(0, 3) == 0);
        set_push(pc, dir, tgt, 12'($urandom_range(0, 4095)), call, ret);
      end
      if ($urandom_range(0, 1) == 1) begin
        if (mq.size() != 0) begin
          h   = mq[0];
          pc  = ($urandom_range(0, 15) == 0) ? h.pc4 + 32'd4 : h.pc4;
          dir = ($urandom_range(0, 7) == 0) ? ~h.dir : h.dir;
          tgt = ($urandom_range(0, 7) == 0) ? 32'h9000 + 32'($urandom_range(0, 3) * 4) : h.tgt;
          set_res(pc, dir, tgt);
        end else begin
          set_res(32'h8000, 1'($urandom_range(0, 1)), 32'h9000);
        end
        bus.soin_bpredictor_stall = ($urandom_range(0, 7) == 0);
      end
      cycle();
      reset = 1'b0;
    end

    cycle();
    cycle();
    cycle();
    done = 1'b1;
  end

endmodule
